key_repeat: RTL and testbench

//  Turns held keypad/button input into discrete key events with delayed auto-repeat (DAS/ARR).

---
 rtl/key_repeat_if.sv | 22 ++
 rtl/key_repeat.sv | 108 ++++++++++
 tb/tb_key_repeat.sv | 99 +++++++++
 3 files changed

// File: rtl/key_repeat_if.sv
// rtl/key_repeat_if.sv - key event bundle between key synchronizer and game control
interface key_repeat_if;
    logic [19:0] keys;
    logic        strobe;
    logic        en;
    logic        key_valid;
    logic [4:0]  key_code;
    logic        key_rpt;
    logic        key_held;

    // Upstream/stimulus side drives keys and strobe, observes events
    modport master (
        output keys, strobe, en,
        input  key_valid, key_code, key_rpt, key_held
    );

    // Key repeat engine side
    modport slave (
        input  keys, strobe, en,
        output key_valid, key_code, key_rpt, key_held
    );
endinterface

// File: rtl/key_repeat.sv
// rtl/key_repeat.sv - held key to discrete events with delayed auto-repeat
module key_repeat #(
    parameter int DAS   = 10000,
    parameter int ARR   = 2000,
    parameter int CNT_W = 24
) (
    input  logic         clk,
    input  logic         rst,
    key_repeat_if.slave  kr
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DAS_TC = CNT_W'(DAS - 1);
    localparam logic [CNT_W-1:0] ARR_TC = CNT_W'(ARR - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_valid_q, key_valid_d;
    logic [4:0]       key_code_q, key_code_d;
    logic             key_rpt_q, key_rpt_d;
    logic             key_held_q;
    logic [4:0]       enc;
    logic             any_key;
    logic [CNT_W-1:0] term;

    // Priority encode: highest pressed key wins, 0 when nothing is pressed
    always_comb begin
        enc = 5'd0;
        for (int i = 0; i < 20; i++) begin
            if (kr.keys[i]) begin
                enc = 5'(i);
            end
        end
    end

    assign any_key = |kr.keys;
    assign term    = (state_q == ST_REPEAT) ? ARR_TC : DAS_TC;

    // Next-state and event decision; counter restarts on every state entry and event
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_rpt_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (kr.strobe && any_key && kr.en) begin
                    key_valid_d = 1'b1;
                    key_code_d  = enc;
                    state_d     = ST_DELAY;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                if (!kr.en || !any_key) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (kr.strobe || (enc != key_code_q)) begin
                    // Re-press or priority change restarts the full initial delay
                    key_valid_d = 1'b1;
                    key_code_d  = enc;
                    state_d     = ST_DELAY;
                    cnt_d       = '0;
                end else if (cnt_q == term) begin
                    key_valid_d = 1'b1;
                    key_rpt_d   = 1'b1;
                    state_d     = ST_REPEAT;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 5'd0;
            key_rpt_q   <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_rpt_q   <= key_rpt_d;
            key_held_q  <= (state_d != ST_IDLE);
        end
    end

    assign kr.key_valid = key_valid_q;
    assign kr.key_code  = key_code_q;
    assign kr.key_rpt   = key_rpt_q;
    assign kr.key_held  = key_held_q;
endmodule

// File: tb/tb_key_repeat.sv
// tb/tb_key_repeat.sv - directed self-checking bench for key_repeat
module tb_key_repeat;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    key_repeat_if kr ();

    key_repeat #(.DAS(8), .ARR(3), .CNT_W(24)) dut (
        .clk (clk),
        .rst (rst),
        .kr  (kr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Check outputs seen in this cycle, then drive this cycle's inputs
    task automatic cyc(input string tag, input logic [19:0] k, input logic s, input logic e,
                       input logic r, input logic ev, input logic [4:0] code, input logic rpt,
                       input logic held);
        @(negedge clk);
        check_eq({tag, "_valid"}, 32'(kr.key_valid), 32'(ev));
        check_eq({tag, "_held"},  32'(kr.key_held),  32'(held));
        if (ev) begin
            check_eq({tag, "_code"}, 32'(kr.key_code), 32'(code));
            check_eq({tag, "_rpt"},  32'(kr.key_rpt),  32'(rpt));
        end
        kr.keys   = k;
        kr.strobe = s;
        kr.en     = e;
        rst       = r;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        kr.keys   = 20'hFFFFF;
        kr.strobe = 1'b1;
        kr.en     = 1'b1;

        // 1. reset with everything asserted
        cyc("rst1", 20'hFFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        check_eq("rst1_code", 32'(kr.key_code), 32'd0);
        check_eq("rst1_rpt",  32'(kr.key_rpt),  32'd0);
        cyc("rst2", 20'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        check_eq("rst2_code", 32'(kr.key_code), 32'd0);
        check_eq("rst2_rpt",  32'(kr.key_rpt),  32'd0);
        for (int k = 0; k < 3; k++)
            cyc("idle", 20'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        // 2. tap
        for (int k = 0; k <= 8; k++)
            cyc("tap", (k <= 2) ? 20'h00010 : 20'h0, k == 0, 1'b1, 1'b0,
                k == 1, 5'd4, 1'b0, (k >= 1 && k <= 3));

        // 3. hold
        for (int k = 0; k <= 24; k++)
            cyc("hold", (k <= 19) ? 20'h00080 : 20'h0, k == 0, 1'b1, 1'b0,
                (k == 1 || k == 9 || k == 12 || k == 15 || k == 18), 5'd7, k != 1,
                (k >= 1 && k <= 20));

        // 4. priority change
        for (int k = 0; k <= 20; k++)
            cyc("chg", (k < 5) ? 20'h00008 : ((k <= 15) ? 20'h01008 : 20'h0), k == 0, 1'b1, 1'b0,
                (k == 1 || k == 6 || k == 14), (k == 1) ? 5'd3 : 5'd12, k == 14,
                (k >= 1 && k <= 16));
        check_eq("chg_code_hold", 32'(kr.key_code), 32'd12);

        // 5. multi-key, then strobe with no keys
        for (int k = 0; k <= 12; k++)
            cyc("multi", (k < 4) ? 20'h80001 : 20'h0, k == 0, 1'b1, 1'b0,
                k == 1, 5'd19, 1'b0, (k >= 1 && k <= 4));
        for (int k = 0; k <= 5; k++)
            cyc("nokey", 20'h0, k == 0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        // 6. reset mid-operation, then strobe with en=0
        for (int k = 0; k <= 20; k++)
            cyc("midrst", 20'h00004, k == 0, 1'b1, k == 13,
                (k == 1 || k == 9 || k == 12), 5'd2, k != 1, (k >= 1 && k <= 13));
        for (int k = 0; k <= 8; k++)
            cyc("dis", 20'h00004, k == 0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc("end", 20'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc("end", 20'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
